// File: rtl/if_stage_mo_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_mo_pkg;

    localparam int XLEN = 32;

    // Boot address and general exception vector of the core.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [XLEN-1:0] EXC_VECTOR       = 32'hbfc00380;

    // One instruction-buffer entry: {pc, inst, adel}.
    localparam int IBUF_ENTRY_W = XLEN + XLEN + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            adel;
    } ibuf_entry_t;

    // Builds a buffer entry; address-error entries always carry inst=0.
    function automatic ibuf_entry_t make_entry(input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] inst,
                                               input logic            adel);
        ibuf_entry_t e;
        e.pc   = pc;
        e.inst = adel ? '0 : inst;
        e.adel = adel;
        return e;
    endfunction

endpackage

// File: rtl/if_stage_mo_fetch_fifo.sv
// Small synchronous FIFO used for the PC queue and the instruction buffer.
// Clear has priority over push/pop; push into a full FIFO is only taken when
// a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/if_stage_mo.sv
// Instruction-fetch stage with several requests in flight on the
// addr_ok/data_ok bus and a small instruction buffer in front of decode.
//
// Handshakes: a request is accepted on a cycle where inst_sram_req and
// inst_sram_addr_ok are both 1; each data_ok returns exactly one earlier
// accepted request, in order. Decode takes the buffer head on a cycle where
// fs_to_ds_valid and ds_allowin are both 1; fs_* are stable until then.
module if_stage_mo
    import if_stage_mo_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adel,
    output logic        inst_sram_req,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int OCW = $clog2(MAX_OUTSTANDING+1);
    localparam int ICW = $clog2(IBUF_DEPTH+1);

    logic [31:0]    r_fetch_pc;
    logic [OCW-1:0] r_out_cnt;
    logic [OCW-1:0] r_discard_cnt;
    logic           r_halted;

    logic [OCW-1:0] w_out_cnt_nxt;
    logic [OCW-1:0] w_discard_cnt_nxt;
    logic [OCW-1:0] w_live_out;
    logic           w_credit_ok;
    logic           w_req;
    logic           w_accept;
    logic           w_resp;
    logic           w_resp_drop;
    logic           w_resp_live;
    logic           w_adel_push;

    logic [31:0]    w_pcq_head;
    logic [OCW-1:0] w_pcq_count;
    logic           w_pcq_full;
    logic           w_pcq_empty;

    ibuf_entry_t    w_ibuf_in;
    ibuf_entry_t    w_ibuf_head;
    logic [ICW-1:0] w_ibuf_count;
    logic           w_ibuf_full;
    logic           w_ibuf_empty;
    logic           w_ibuf_push;
    logic           w_ibuf_pop;

    logic           w_unused;

    // Live requests are the outstanding ones whose data will be kept. A new
    // request is only issued if the buffer has room for every live response,
    // so a kept data_ok always finds a free slot.
    assign w_live_out  = r_out_cnt - r_discard_cnt;
    assign w_credit_ok = (32'(w_live_out) + 32'(w_ibuf_count)) < 32'(IBUF_DEPTH);

    assign w_req = !reset && !redirect_valid && !r_halted
                && (r_fetch_pc[1:0] == 2'b00)
                && (32'(r_out_cnt) < 32'(MAX_OUTSTANDING))
                && w_credit_ok;

    assign w_accept = w_req && inst_sram_addr_ok;

    // Responses are in order: the first discard_cnt of them belong to the
    // stream abandoned by the last redirect. A redirect drops this cycle's
    // response too; it is folded into the new discard count.
    assign w_resp      = inst_sram_data_ok && (r_out_cnt != '0);
    assign w_resp_drop = w_resp && !redirect_valid && (r_discard_cnt != '0);
    assign w_resp_live = w_resp && !redirect_valid && (r_discard_cnt == '0) && !w_pcq_empty;

    // A misaligned fetch PC becomes an address-error entry once every live
    // request ahead of it has returned, keeping program order in the buffer.
    assign w_adel_push = !redirect_valid && !r_halted
                      && (r_fetch_pc[1:0] != 2'b00)
                      && w_pcq_empty && !w_ibuf_full;

    assign w_ibuf_push = w_resp_live || w_adel_push;
    assign w_ibuf_pop  = !w_ibuf_empty && ds_allowin && !redirect_valid;

    // Selects what goes into the buffer: fetched data or an address-error entry.
    always_comb begin
        w_ibuf_in = make_entry(r_fetch_pc, '0, 1'b1);
        if (w_resp_live) begin
            w_ibuf_in = make_entry(w_pcq_head, inst_sram_rdata, 1'b0);
        end
    end

    // Next values of the outstanding and discard counters.
    always_comb begin
        w_out_cnt_nxt     = r_out_cnt;
        w_discard_cnt_nxt = r_discard_cnt;
        if (w_accept && !w_resp) begin
            w_out_cnt_nxt = r_out_cnt + OCW'(1);
        end else if (!w_accept && w_resp) begin
            w_out_cnt_nxt = r_out_cnt - OCW'(1);
        end
        if (redirect_valid) begin
            w_discard_cnt_nxt = w_out_cnt_nxt;
        end else if (w_resp_drop) begin
            w_discard_cnt_nxt = r_discard_cnt - OCW'(1);
        end
    end

    // Fetch PC, counters and halt flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_out_cnt     <= '0;
            r_discard_cnt <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_out_cnt     <= w_out_cnt_nxt;
            r_discard_cnt <= w_discard_cnt_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_halted   <= 1'b0;
            end else begin
                if (w_accept)    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_adel_push) r_halted   <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pcq (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (w_resp_live),
        .i_clear (redirect_valid),
        .o_head  (w_pcq_head),
        .o_count (w_pcq_count),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty)
    );

    fetch_fifo #(
        .WIDTH (IBUF_ENTRY_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_ibuf_push),
        .i_data  (w_ibuf_in),
        .i_pop   (w_ibuf_pop),
        .i_clear (redirect_valid),
        .o_head  (w_ibuf_head),
        .o_count (w_ibuf_count),
        .o_full  (w_ibuf_full),
        .o_empty (w_ibuf_empty)
    );

    // PC-queue occupancy mirrors live_out and is not needed here.
    assign w_unused = ^{w_pcq_count, w_pcq_full};

    assign inst_sram_req   = w_req;
    assign inst_sram_addr  = r_fetch_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    assign fs_to_ds_valid = !w_ibuf_empty;
    assign fs_pc          = w_ibuf_head.pc;
    assign fs_inst        = w_ibuf_head.inst;
    assign fs_adel        = w_ibuf_head.adel;

endmodule

// File: tb/tb_if_stage_mo.sv
// Directed bench for if_stage_mo with an in-order addr_ok/data_ok slave.
module tb_if_stage_mo;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adel;
    logic        inst_sram_req;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] pend_q[$];
    logic [31:0] req_log[$];
    int          acc_cyc[$];
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    int          cyc = 0;
    int          max_pend = 0;
    logic        slave_aok = 1'b0;
    logic        slave_dok = 1'b0;
    logic        s_req = 1'b0;

    if_stage_mo dut (
        .clk               (clk),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst),
        .fs_adel           (fs_adel),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wen     (inst_sram_wen),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory contents seen by the slave
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00ff00ff;
    endfunction

    function automatic logic [64:0] ent(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic adel);
        return {pc, inst, adel};
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // driver: slave answers the oldest accepted request when enabled
    task automatic drive_slave();
        inst_sram_addr_ok = slave_aok;
        if (slave_dok && pend_q.size() > 0) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = inst_of(pend_q[0]);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
        end
    endtask

    // one clock: drive at negedge, sample, update bus model at posedge
    task automatic step();
        logic        acc;
        logic        dok;
        logic [31:0] a;
        drive_slave();
        #1;
        acc   = inst_sram_req && inst_sram_addr_ok;
        a     = inst_sram_addr;
        dok   = inst_sram_data_ok;
        s_req = inst_sram_req;
        if (fs_to_ds_valid && ds_allowin && !redirect_valid)
            got_q.push_back({fs_pc, fs_inst, fs_adel});
        @(posedge clk);
        if (dok) void'(pend_q.pop_front());
        if (acc) begin
            pend_q.push_back(a);
            req_log.push_back(a);
            acc_cyc.push_back(cyc);
        end
        if (pend_q.size() > max_pend) max_pend = pend_q.size();
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        req_log.delete();
        acc_cyc.delete();
    endtask

    // scoreboard: compare delivered entries against expected queue
    task automatic compare_stream(input string tag);
        logic [64:0] obs;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = 'x;
            if (i < got_q.size()) obs = got_q[i];
            check($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
        end
    endtask

    task automatic drain();
        logic idle;
        slave_aok  = 1'b0;
        slave_dok  = 1'b1;
        ds_allowin = 1'b1;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            step();
            idle = (pend_q.size() == 0) && !fs_to_ds_valid;
        end
        check("drain_done", 65'(idle), 65'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        ds_allowin        = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
        check("rst_req", 65'(inst_sram_req), 65'd0);
        check("wen_zero", 65'(inst_sram_wen), 65'd0);
        check("wdata_zero", 65'(inst_sram_wdata), 65'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: streaming with 1-cycle data latency
        slave_aok = 1'b1; slave_dok = 1'b1; ds_allowin = 1'b1;
        repeat (8) step();
        check("t1_req0", 65'(req_log[0]), 65'(32'hbfc00000));
        check("t1_req1", 65'(req_log[1]), 65'(32'hbfc00004));
        check("t1_b2b", 65'(acc_cyc[1] - acc_cyc[0]), 65'd1);
        check("t1_count", 65'(got_q.size()), 65'd6);
        exp_q.push_back(ent(32'hbfc00000, inst_of(32'hbfc00000), 1'b0));
        exp_q.push_back(ent(32'hbfc00004, inst_of(32'hbfc00004), 1'b0));
        exp_q.push_back(ent(32'hbfc00008, inst_of(32'hbfc00008), 1'b0));
        exp_q.push_back(ent(32'hbfc0000c, inst_of(32'hbfc0000c), 1'b0));
        exp_q.push_back(ent(32'hbfc00010, inst_of(32'hbfc00010), 1'b0));
        exp_q.push_back(ent(32'hbfc00014, inst_of(32'hbfc00014), 1'b0));
        compare_stream("t1_stream");
        check("t1_maxout", 65'(max_pend <= 2), 65'd1);

        // reset in the middle of traffic; the slave is reset with it
        reset = 1'b1;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        #1;
        check("midrst_valid", 65'(fs_to_ds_valid), 65'd0);
        check("midrst_req", 65'(inst_sram_req), 65'd0);
        pend_q.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 2: decode stalled, buffer fills to its credit limit
        ds_allowin = 1'b0; slave_aok = 1'b1; slave_dok = 1'b1;
        repeat (8) step();
        check("t2_nreq", 65'(req_log.size()), 65'd4);
        check("t2_req3", 65'(req_log[3]), 65'(32'hbfc0000c));
        check("t2_req_off", 65'(s_req), 65'd0);
        check("t2_valid", 65'(fs_to_ds_valid), 65'd1);
        check("t2_headpc", 65'(fs_pc), 65'(32'hbfc00000));
        slave_aok = 1'b0; ds_allowin = 1'b1;
        repeat (6) step();
        check("t2_count", 65'(got_q.size()), 65'd4);
        exp_q.push_back(ent(32'hbfc00000, inst_of(32'hbfc00000), 1'b0));
        exp_q.push_back(ent(32'hbfc00004, inst_of(32'hbfc00004), 1'b0));
        exp_q.push_back(ent(32'hbfc00008, inst_of(32'hbfc00008), 1'b0));
        exp_q.push_back(ent(32'hbfc0000c, inst_of(32'hbfc0000c), 1'b0));
        compare_stream("t2_stream");

        // 3: redirect with two requests outstanding
        clear_logs();
        slave_dok = 1'b0; slave_aok = 1'b1;
        repeat (3) step();
        check("t3_nreq", 65'(req_log.size()), 65'd2);
        check("t3_req0", 65'(req_log[0]), 65'(32'hbfc00010));
        check("t3_req1", 65'(req_log[1]), 65'(32'hbfc00014));
        check("t3_outlimit", 65'(s_req), 65'd0);
        redirect_to(32'hbfc00380);
        check("t3_redir_noreq", 65'(s_req), 65'd0);
        slave_dok = 1'b1;
        repeat (6) step();
        drain();
        check("t3_newreq", 65'(req_log[2]), 65'(32'hbfc00380));
        exp_q.push_back(ent(32'hbfc00380, inst_of(32'hbfc00380), 1'b0));
        exp_q.push_back(ent(32'hbfc00384, inst_of(32'hbfc00384), 1'b0));
        compare_stream("t3_stream");

        // 4: redirect in the same cycle as a data_ok, one more outstanding
        clear_logs();
        slave_dok = 1'b0; slave_aok = 1'b1;
        repeat (2) step();
        slave_aok = 1'b0;
        check("t4_nreq", 65'(req_log.size()), 65'd2);
        slave_dok = 1'b1;
        redirect_to(32'hbfc01000);
        slave_aok = 1'b1;
        repeat (5) step();
        drain();
        check("t4_newreq", 65'(req_log[2]), 65'(32'hbfc01000));
        exp_q.push_back(ent(32'hbfc01000, inst_of(32'hbfc01000), 1'b0));
        exp_q.push_back(ent(32'hbfc01004, inst_of(32'hbfc01004), 1'b0));
        compare_stream("t4_stream");

        // 5: misaligned redirect target -> address-error entry and halt
        clear_logs();
        slave_aok = 1'b1; slave_dok = 1'b1; ds_allowin = 1'b0;
        redirect_to(32'h80000002);
        step();
        check("t5_valid", 65'(fs_to_ds_valid), 65'd1);
        check("t5_pc", 65'(fs_pc), 65'(32'h80000002));
        check("t5_adel", 65'(fs_adel), 65'd1);
        check("t5_inst", 65'(fs_inst), 65'd0);
        check("t5_noreq_a", 65'(s_req), 65'd0);
        ds_allowin = 1'b1;
        repeat (4) step();
        check("t5_nreq", 65'(req_log.size()), 65'd0);
        check("t5_count", 65'(got_q.size()), 65'd1);
        check("t5_noreq_b", 65'(s_req), 65'd0);
        check("t5_empty", 65'(fs_to_ds_valid), 65'd0);
        exp_q.push_back(ent(32'h80000002, 32'h0, 1'b1));
        compare_stream("t5_adel");
        clear_logs();
        redirect_to(32'h80000000);
        repeat (3) step();
        drain();
        check("t5_resume_req", 65'(req_log[0]), 65'(32'h80000000));
        exp_q.push_back(ent(32'h80000000, inst_of(32'h80000000), 1'b0));
        compare_stream("t5_resume");

        // 6: fetch address wraps past 2^32
        clear_logs();
        slave_aok = 1'b1;
        redirect_to(32'hfffffff8);
        repeat (6) step();
        drain();
        check("t6_req0", 65'(req_log[0]), 65'(32'hfffffff8));
        check("t6_req1", 65'(req_log[1]), 65'(32'hfffffffc));
        check("t6_req2", 65'(req_log[2]), 65'(32'h00000000));
        check("t6_req3", 65'(req_log[3]), 65'(32'h00000004));
        exp_q.push_back(ent(32'hfffffff8, inst_of(32'hfffffff8), 1'b0));
        exp_q.push_back(ent(32'hfffffffc, inst_of(32'hfffffffc), 1'b0));
        exp_q.push_back(ent(32'h00000000, inst_of(32'h00000000), 1'b0));
        exp_q.push_back(ent(32'h00000004, inst_of(32'h00000004), 1'b0));
        compare_stream("t6_stream");

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
